instruction_encoder_loader: RTL and testbench

INSTRUCTION_ENCODER_LOADER -- requirements
Module: instruction_encoder_loader

---
 rtl/mips_pkg.sv | 42 ++++
 rtl/instr_field_packer.sv | 44 ++++
 rtl/instruction_encoder_loader.sv | 120 ++++++++++++
 tb/tb_instruction_encoder_loader.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS encoding constants.
// Holds the loader's op_sel codes, the 6-bit primary opcodes and the R-type
// funct codes. The decoder uses the same constants, so encoder and decoder
// stay in agreement. Also holds the loader FSM state type.
package mips_pkg;

    // Compact op selector presented to the loader; 10..15 are illegal.
    typedef enum logic [3:0] {
        OP_SLL  = 4'd0,
        OP_OR   = 4'd1,
        OP_ADD  = 4'd2,
        OP_ADDI = 4'd3,
        OP_ANDI = 4'd4,
        OP_SW   = 4'd5,
        OP_LW   = 4'd6,
        OP_BEQ  = 4'd7,
        OP_BNE  = 4'd8,
        OP_J    = 4'd9
    } op_sel_e;

    // Primary opcodes (instruction bits [31:26]).
    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_J     = 6'h02;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_BNE   = 6'h05;
    localparam logic [5:0] OPC_ADDI  = 6'h08;
    localparam logic [5:0] OPC_ANDI  = 6'h0C;
    localparam logic [5:0] OPC_LW    = 6'h23;
    localparam logic [5:0] OPC_SW    = 6'h2B;

    // R-type funct codes (instruction bits [5:0]).
    localparam logic [5:0] FUNCT_SLL = 6'h00;
    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_OR  = 6'h25;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } load_state_e;

endpackage

// File: rtl/instr_field_packer.sv
// instr_field_packer: combinational MIPS instruction packer.
// Ports:
//   i_op_sel          op selector (mips_pkg::op_sel_e codes; 10..15 illegal)
//   i_rs/i_rt/i_rd    register fields
//   i_shamt           shift amount
//   i_imm             16-bit immediate (I-type)
//   i_target          26-bit jump target (J)
//   o_word            encoded 32-bit instruction (0 when illegal)
//   o_illegal         op_sel is not a supported code
module instr_field_packer
    import mips_pkg::*;
(
    input  logic [3:0]  i_op_sel,
    input  logic [4:0]  i_rs,
    input  logic [4:0]  i_rt,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_shamt,
    input  logic [15:0] i_imm,
    input  logic [25:0] i_target,
    output logic [31:0] o_word,
    output logic        o_illegal
);

    always_comb begin
        o_word    = 32'h0;
        o_illegal = 1'b0;
        case (i_op_sel)
            // SLL shifts rt only; rs is architecturally zero.
            OP_SLL:  o_word = {OPC_RTYPE, 5'd0, i_rt, i_rd, i_shamt, FUNCT_SLL};
            // OR/ADD do not shift; shamt must be zero.
            OP_OR:   o_word = {OPC_RTYPE, i_rs, i_rt, i_rd, 5'd0, FUNCT_OR};
            OP_ADD:  o_word = {OPC_RTYPE, i_rs, i_rt, i_rd, 5'd0, FUNCT_ADD};
            OP_ADDI: o_word = {OPC_ADDI, i_rs, i_rt, i_imm};
            OP_ANDI: o_word = {OPC_ANDI, i_rs, i_rt, i_imm};
            OP_SW:   o_word = {OPC_SW,   i_rs, i_rt, i_imm};
            OP_LW:   o_word = {OPC_LW,   i_rs, i_rt, i_imm};
            OP_BEQ:  o_word = {OPC_BEQ,  i_rs, i_rt, i_imm};
            OP_BNE:  o_word = {OPC_BNE,  i_rs, i_rt, i_imm};
            OP_J:    o_word = {OPC_J, i_target};
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instruction_encoder_loader.sv
// instruction_encoder_loader: encodes MIPS field sets into 32-bit words and
// streams them into an instruction memory, one word per cycle.
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   start, finish       open a session at address 0 / close the session
//   in_valid, in_ready  field-set handshake
//   op_sel..target      instruction fields
//   mem_we/addr/wdata   registered memory write port (1-cycle latency)
//   word_count          words written this session (saturates at DEPTH)
//   done                session closed
//   err_illegal         sticky: an illegal op_sel was accepted this session
module instruction_encoder_loader
    import mips_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              finish,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        op_sel,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [4:0]        shamt,
    input  logic [15:0]       imm,
    input  logic [25:0]       target,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   word_count,
    output logic              done,
    output logic              err_illegal
);

    localparam logic [ADDR_W:0] DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] CNT_ONE   = 1;

    load_state_e       r_state;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;
    logic [ADDR_W:0]   r_word_count;
    logic              r_done;
    logic              r_err;

    logic [31:0]       w_word;
    logic              w_illegal;
    logic              w_ready;
    logic              w_accept;
    logic              w_write;

    instr_field_packer u_packer (
        .i_op_sel  (op_sel),
        .i_rs      (rs),
        .i_rt      (rt),
        .i_rd      (rd),
        .i_shamt   (shamt),
        .i_imm     (imm),
        .i_target  (target),
        .o_word    (w_word),
        .o_illegal (w_illegal)
    );

    // Start blocks acceptance so a word can never land in the session being
    // torn down; reset blocks it so nothing is accepted in the reset cycle.
    // A full memory stops acceptance instead of wrapping.
    assign w_ready  = (r_state == ST_LOAD) && (r_word_count != DEPTH_CNT)
                      && !start && !reset;
    assign w_accept = in_valid && w_ready;
    assign w_write  = w_accept && !w_illegal;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_word_count <= '0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_mem_we <= w_write;
            if (w_write) begin
                r_mem_addr  <= r_word_count[ADDR_W-1:0];
                r_mem_wdata <= w_word;
            end

            if (start) begin
                // A write registered last cycle is already on the port and
                // completes at its old address; only the counters restart.
                r_state      <= ST_LOAD;
                r_done       <= 1'b0;
                r_word_count <= '0;
                r_err        <= 1'b0;
            end else begin
                if (w_accept) begin
                    if (w_illegal) r_err <= 1'b1;
                    else           r_word_count <= r_word_count + CNT_ONE;
                end
                // A same-cycle accept is still written (handled above).
                if (r_state == ST_LOAD && finish) begin
                    r_state <= ST_DONE;
                    r_done  <= 1'b1;
                end
            end
        end
    end

    assign in_ready    = w_ready;
    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign word_count  = r_word_count;
    assign done        = r_done;
    assign err_illegal = r_err;

endmodule

// File: tb/tb_instruction_encoder_loader.sv
module tb_instruction_encoder_loader;

    typedef struct {
        logic [3:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  sh;
        logic [15:0] imm;
        logic [25:0] tgt;
        logic [31:0] exp;
        bit          legal;
    } vec_t;

    typedef struct {
        logic [5:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic        clk;
    logic        reset;
    logic        start, finish, in_valid;
    logic        start2, finish2, in_valid2;
    logic [3:0]  op_sel;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;
    logic [25:0] target;

    logic        in_ready, mem_we, done, err_illegal;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [6:0]  word_count;

    logic        in_ready2, mem_we2, done2, err_illegal2;
    logic [1:0]  mem_addr2;
    logic [31:0] mem_wdata2;
    logic [2:0]  word_count2;

    int n_pass  = 0;
    int n_total = 0;
    wr_t q[$];
    wr_t q2[$];
    vec_t vecs[$];

    instruction_encoder_loader #(.ADDR_W(6)) dut (
        .clk(clk), .reset(reset), .start(start), .finish(finish),
        .in_valid(in_valid), .in_ready(in_ready), .op_sel(op_sel),
        .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .imm(imm), .target(target),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .word_count(word_count), .done(done), .err_illegal(err_illegal)
    );

    instruction_encoder_loader #(.ADDR_W(2)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .finish(finish2),
        .in_valid(in_valid2), .in_ready(in_ready2), .op_sel(op_sel),
        .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .imm(imm), .target(target),
        .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
        .word_count(word_count2), .done(done2), .err_illegal(err_illegal2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fields(input vec_t v);
        op_sel = v.op; rs = v.rs; rt = v.rt; rd = v.rd;
        shamt = v.sh; imm = v.imm; target = v.tgt;
    endtask

    task automatic push(input logic [5:0] a, input logic [31:0] d);
        wr_t w;
        w.addr = a; w.data = d;
        q.push_back(w);
    endtask

    // Scoreboards: every observed write must match the oldest expected one.
    always @(negedge clk) begin
        if (mem_we) begin
            if (q.size() == 0) check("unexpected_write", {26'h0, mem_addr}, 32'hFFFFFFFF);
            else begin
                wr_t w;
                w = q.pop_front();
                check("wr_addr", {26'h0, mem_addr}, {26'h0, w.addr});
                check("wr_data", mem_wdata, w.data);
            end
        end
        if (mem_we2) begin
            if (q2.size() == 0) check("unexpected_write2", {30'h0, mem_addr2}, 32'hFFFFFFFF);
            else begin
                wr_t w;
                w = q2.pop_front();
                check("wr2_addr", {30'h0, mem_addr2}, {26'h0, w.addr});
                check("wr2_data", mem_wdata2, w.data);
            end
        end
    end

    initial begin
        vec_t v;
        int   cnt;
        bit   err;

        reset = 1; start = 0; finish = 0; in_valid = 0;
        start2 = 0; finish2 = 0; in_valid2 = 0;
        op_sel = 0; rs = 0; rt = 0; rd = 0; shamt = 0; imm = 0; target = 0;

        //           op     rs     rt     rd     sh     imm       tgt          exp           legal
        vecs.push_back('{4'd2,  5'd1,  5'd2,  5'd3,  5'd0,  16'h0,    26'h0,       32'h00221820, 1'b1});
        vecs.push_back('{4'd3,  5'd0,  5'd8,  5'd0,  5'd0,  16'h5,    26'h0,       32'h20080005, 1'b1});
        vecs.push_back('{4'd6,  5'd8,  5'd9,  5'd0,  5'd0,  16'h4,    26'h0,       32'h8D090004, 1'b1});
        vecs.push_back('{4'd0,  5'd0,  5'd1,  5'd2,  5'd4,  16'h0,    26'h0,       32'h00011100, 1'b1});
        vecs.push_back('{4'd9,  5'd0,  5'd0,  5'd0,  5'd0,  16'h0,    26'h10,      32'h08000010, 1'b1});
        vecs.push_back('{4'd1,  5'd4,  5'd5,  5'd6,  5'd7,  16'hBEEF, 26'h0,       32'h00853025, 1'b1});
        vecs.push_back('{4'd12, 5'd1,  5'd1,  5'd1,  5'd0,  16'h0,    26'h0,       32'h0,        1'b0});
        vecs.push_back('{4'd4,  5'd3,  5'd4,  5'd31, 5'd31, 16'hFFFF, 26'h0,       32'h3064FFFF, 1'b1});
        vecs.push_back('{4'd5,  5'd29, 5'd31, 5'd0,  5'd0,  16'h8000, 26'h0,       32'hAFBF8000, 1'b1});
        vecs.push_back('{4'd7,  5'd1,  5'd2,  5'd0,  5'd0,  16'h1234, 26'h0,       32'h10221234, 1'b1});
        vecs.push_back('{4'd8,  5'd31, 5'd0,  5'd0,  5'd0,  16'h0,    26'h0,       32'h17E00000, 1'b1});
        vecs.push_back('{4'd2,  5'd1,  5'd2,  5'd3,  5'd3,  16'h0,    26'h0,       32'h00221820, 1'b1});
        vecs.push_back('{4'd0,  5'd5,  5'd1,  5'd2,  5'd4,  16'h0,    26'h0,       32'h00011100, 1'b1});
        vecs.push_back('{4'd9,  5'd7,  5'd7,  5'd7,  5'd7,  16'h0,    26'h3FFFFFF, 32'h0BFFFFFF, 1'b1});
        vecs.push_back('{4'd15, 5'd0,  5'd0,  5'd0,  5'd0,  16'h0,    26'h0,       32'h0,        1'b0});

        // Reset state
        tick(); tick();
        check("rst_in_ready", {31'h0, in_ready}, 32'h0);
        check("rst_mem_we",   {31'h0, mem_we}, 32'h0);
        check("rst_mem_addr", {26'h0, mem_addr}, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_word_count", {25'h0, word_count}, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        check("rst_err", {31'h0, err_illegal}, 32'h0);
        reset = 0;
        tick();
        check("idle_in_ready", {31'h0, in_ready}, 32'h0);

        // Start a session: not ready while start is high
        start = 1; #1;
        check("start_blocks_ready", {31'h0, in_ready}, 32'h0);
        tick();
        start = 0; #1;
        check("load_in_ready", {31'h0, in_ready}, 32'h1);

        // Table-driven back-to-back stream
        cnt = 0; err = 0;
        foreach (vecs[i]) begin
            v = vecs[i];
            set_fields(v);
            in_valid = 1;
            if (v.legal) begin
                push(6'(cnt), v.exp);
                cnt++;
            end else err = 1;
            tick();
        end
        in_valid = 0;
        tick(); tick();
        check("vec_word_count", {25'h0, word_count}, 32'(cnt));
        check("vec_err_illegal", {31'h0, err_illegal}, {31'h0, err});
        check("vec_queue_drained", 32'(q.size()), 32'h0);

        // Accept, then start next cycle: write lands at old address; start clears
        start = 1; tick(); start = 0;
        check("restart_err_clear", {31'h0, err_illegal}, 32'h0);
        check("restart_count_clear", {25'h0, word_count}, 32'h0);
        v = vecs[0]; set_fields(v); in_valid = 1; push(6'd0, v.exp);
        tick();
        in_valid = 0; start = 1; v = vecs[1]; push(6'd1, v.exp);
        // previous accept appears now, while start is high
        tick(); start = 0;
        check("start_clears_count", {25'h0, word_count}, 32'h0);
        // replace the bogus second expectation: nothing else should be written
        void'(q.pop_back());

        // Illegal between two ADDs
        v = vecs[0]; set_fields(v); in_valid = 1; push(6'd0, v.exp); tick();
        v = vecs[6]; set_fields(v); tick();
        v = vecs[11]; set_fields(v); push(6'd1, v.exp); tick();
        in_valid = 0; tick();
        check("ill_word_count", {25'h0, word_count}, 32'h2);
        check("ill_err_set", {31'h0, err_illegal}, 32'h1);

        // Finish with a same-cycle accept
        v = vecs[1]; set_fields(v); in_valid = 1; finish = 1; push(6'd2, v.exp);
        tick();
        in_valid = 0; finish = 0;
        check("finish_done", {31'h0, done}, 32'h1);
        check("finish_count", {25'h0, word_count}, 32'h3);
        check("done_not_ready", {31'h0, in_ready}, 32'h0);
        in_valid = 1; tick(); in_valid = 0;   // ignored in DONE
        check("done_holds", {31'h0, done}, 32'h1);
        start = 1; tick(); start = 0;
        check("start_done_clear", {31'h0, done}, 32'h0);
        check("start_wc_clear", {25'h0, word_count}, 32'h0);
        check("start_err_clear", {31'h0, err_illegal}, 32'h0);

        // Reset in the accept cycle squashes the write
        v = vecs[0]; set_fields(v); in_valid = 1; reset = 1;
        tick();
        in_valid = 0; reset = 0;
        check("sq_mem_we", {31'h0, mem_we}, 32'h0);
        check("sq_in_ready", {31'h0, in_ready}, 32'h0);
        check("sq_word_count", {25'h0, word_count}, 32'h0);
        check("sq_mem_wdata", mem_wdata, 32'h0);
        tick();
        check("sq_mem_we_next", {31'h0, mem_we}, 32'h0);

        // ADDR_W=2: five offered words, only four fit
        start2 = 1; tick(); start2 = 0;
        op_sel = 4'd2; rs = 5'd1; rt = 5'd2; shamt = 5'd0; imm = 0; target = 0;
        in_valid2 = 1;
        for (int k = 0; k < 5; k++) begin
            rd = 5'(k);
            if (k == 4) check("full_not_ready", {31'h0, in_ready2}, 32'h0);
            if (k < 4) begin
                wr_t w;
                w.addr = 6'(k);
                w.data = 32'h00220020 | (32'(k) << 11);
                q2.push_back(w);
            end
            tick();
        end
        in_valid2 = 0;
        tick(); tick();
        check("full_word_count", {29'h0, word_count2}, 32'h4);
        check("full_stays_load", {31'h0, done2}, 32'h0);
        check("full_q2_drained", 32'(q2.size()), 32'h0);
        check("final_q_drained", 32'(q.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
